// File: rtl/reg_spi_bridge_pkg.sv
// Shared definitions for the SPI-to-register bridge: FSM encoding,
// command field positions, word length and synchroniser depth.
package reg_spi_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_RD_LATCH,
        ST_DATA,
        ST_DONE
    } state_t;

    localparam int CMD_BITS      = 8;
    localparam int CMD_WRITE_BIT = 7;
    localparam int ADDR_MSB      = 5;
    localparam int ADDR_LSB      = 0;
    localparam int WORD_BITS     = 32;
    localparam int SYNC_DEPTH    = 2;

    localparam logic [4:0] CMD_LAST  = 5'(CMD_BITS - 1);
    localparam logic [4:0] WORD_LAST = 5'(WORD_BITS - 1);
    localparam logic [5:0] ADDR_STEP = 6'd4;

endpackage

// File: rtl/reg_spi_bridge_spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous SPI input, with
// single-clk rise and fall pulses derived from the synchronised level.
module spi_sync_edge
    import reg_spi_bridge_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_DEPTH-1:0] sync;
    logic                  prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= {SYNC_DEPTH{RESET_VAL}};
            prev <= RESET_VAL;
        end else begin
            sync <= {sync[SYNC_DEPTH-2:0], din};
            prev <= sync[SYNC_DEPTH-1];
        end
    end

    assign level = sync[SYNC_DEPTH-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/reg_spi_bridge.sv
// SPI mode-0 slave bridging 8-bit commands and 32-bit words onto a
// register bus; REG_SPI_AUTOINC_EN enables multi-word bursts.
module reg_spi_bridge
    import reg_spi_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        spi_sck,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic [5:0]  reg_addr,
    output logic [31:0] reg_wdata,
    output logic        reg_wstrobe,
    input  logic [31:0] reg_rdata
);

    logic sck_s, sck_rise, sck_fall;
    logic cs_n_s, cs_rise, cs_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.RESET_VAL(1'b0)) u_sck (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (spi_sck),
        .level   (sck_s),
        .rise    (sck_rise),
        .fall    (sck_fall)
    );

    spi_sync_edge #(.RESET_VAL(1'b1)) u_cs (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (spi_cs_n),
        .level   (cs_n_s),
        .rise    (cs_rise),
        .fall    (cs_fall)
    );

    spi_sync_edge #(.RESET_VAL(1'b0)) u_mosi (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (spi_mosi),
        .level   (mosi_s),
        .rise    (mosi_rise_unused),
        .fall    (mosi_fall_unused)
    );

    state_t      state;
    logic [4:0]  bit_cnt;
    logic [6:0]  cmd_sr;
    logic        is_write;
    logic [31:0] rd_sr;
    logic        miso_q;
    logic [1:0]  cs_hi_cnt;
    logic [7:0]  cmd_next;
    logic        cs_armed;
    logic        sck_unused;

    assign cmd_next   = {cmd_sr, mosi_s};
    assign sck_unused = sck_s;
    // A cs_n fall only starts a transaction once cs_n has been seen high
    // long enough to flush the synchroniser, so a reset released while
    // the MCU still holds cs_n low cannot start mid-stream.
    assign cs_armed   = (cs_hi_cnt == 2'd3);
    assign spi_miso   = miso_q & ~cs_n_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            cmd_sr      <= '0;
            is_write    <= 1'b0;
            rd_sr       <= '0;
            miso_q      <= 1'b0;
            cs_hi_cnt   <= '0;
            reg_addr    <= '0;
            reg_wdata   <= '0;
            reg_wstrobe <= 1'b0;
        end else begin
            reg_wstrobe <= 1'b0;
            if (!cs_n_s)
                cs_hi_cnt <= '0;
            else if (!cs_armed)
                cs_hi_cnt <= cs_hi_cnt + 2'd1;

            if (cs_rise) begin
                state   <= ST_IDLE;
                bit_cnt <= '0;
                miso_q  <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (cs_fall && cs_armed) begin
                            state   <= ST_CMD;
                            bit_cnt <= '0;
                        end
                    end
                    ST_CMD: begin
                        if (sck_rise) begin
                            cmd_sr  <= cmd_next[6:0];
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == CMD_LAST) begin
                                bit_cnt  <= '0;
                                is_write <= cmd_next[CMD_WRITE_BIT];
                                reg_addr <= {cmd_next[ADDR_MSB:ADDR_LSB+2],
                                             2'b00};
                                state    <= cmd_next[CMD_WRITE_BIT]
                                          ? ST_DATA : ST_RD_LATCH;
                            end
                        end
                    end
                    ST_RD_LATCH: begin
                        rd_sr  <= reg_rdata;
                        miso_q <= reg_rdata[WORD_BITS-1];
                        state  <= ST_DATA;
                    end
                    ST_DATA: begin
`ifdef REG_SPI_AUTOINC_EN
                        // Step the address after the strobe cycle so the
                        // responder sees a stable address while writing.
                        if (reg_wstrobe)
                            reg_addr <= reg_addr + ADDR_STEP;
`endif
                        if (sck_rise) begin
                            bit_cnt <= bit_cnt + 5'd1;
                            if (is_write)
                                reg_wdata <= {reg_wdata[30:0], mosi_s};
                            if (bit_cnt == WORD_LAST) begin
                                bit_cnt     <= '0;
                                reg_wstrobe <= is_write;
                                miso_q      <= 1'b0;
`ifdef REG_SPI_AUTOINC_EN
                                if (!is_write) begin
                                    reg_addr <= reg_addr + ADDR_STEP;
                                    state    <= ST_RD_LATCH;
                                end
`else
                                state <= ST_DONE;
`endif
                            end
                        end else if (sck_fall && !is_write
                                     && bit_cnt != '0) begin
                            // The fall right after a word boundary is
                            // skipped: the fresh word is already on miso.
                            rd_sr  <= {rd_sr[30:0], 1'b0};
                            miso_q <= rd_sr[WORD_BITS-2];
                        end
                    end
                    ST_DONE: begin
                        bit_cnt <= '0;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reg_spi_bridge.sv
// Directed self-checking bench for reg_spi_bridge (SPI mode 0 master model).
module tb_reg_spi_bridge;

    localparam int HALF = 60;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        spi_sck = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic [5:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_wstrobe;
    logic [31:0] reg_rdata;

    int checks = 0;
    int errors = 0;
    int strobes = 0;
    logic [5:0]  s_addr[$];
    logic [31:0] s_data[$];

    always #5 clk = ~clk;

    reg_spi_bridge dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .spi_sck     (spi_sck),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .reg_addr    (reg_addr),
        .reg_wdata   (reg_wdata),
        .reg_wstrobe (reg_wstrobe),
        .reg_rdata   (reg_rdata)
    );

    always_comb begin
        case (reg_addr)
            6'h20:   reg_rdata = 32'h0000000A;
            6'h3C:   reg_rdata = 32'h80000001;
            6'h00:   reg_rdata = 32'hCAFEF00D;
            default: reg_rdata = {26'h0, reg_addr};
        endcase
    end

    always @(negedge clk) begin
        if (reg_wstrobe) begin
            strobes++;
            s_addr.push_back(reg_addr);
            s_data.push_back(reg_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h",
                   tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [63:0] data, input int n,
                        output logic [63:0] rx);
        rx = '0;
        for (int i = n - 1; i >= 0; i--) begin
            spi_mosi = data[i];
            #(HALF);
            rx = {rx[62:0], spi_miso};
            spi_sck = 1'b1;
            #(HALF);
            spi_sck = 1'b0;
        end
    endtask

    task automatic cs_low();
        spi_cs_n = 1'b0;
        #(HALF);
    endtask

    task automatic cs_high();
        #(HALF);
        spi_cs_n = 1'b1;
        #(4 * HALF);
    endtask

    task automatic write_word(input logic [7:0] cmd,
                              input logic [31:0] data);
        logic [63:0] rx;
        cs_low();
        xfer({56'h0, cmd}, 8, rx);
        xfer({32'h0, data}, 32, rx);
        cs_high();
    endtask

    initial begin
        logic [63:0] rx;
        int base;

        repeat (5) @(negedge clk);
        check("rst_addr", {26'h0, reg_addr}, 32'h0);
        check("rst_wdata", reg_wdata, 32'h0);
        check("rst_wstrobe", {31'h0, reg_wstrobe}, 32'h0);
        check("rst_miso", {31'h0, spi_miso}, 32'h0);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);

        // Single write
        base = strobes;
        write_word(8'h84, 32'h00000280);
        check("wr_count", strobes - base, 1);
        check("wr_addr", {26'h0, s_addr[base]}, 32'h04);
        check("wr_data", s_data[base], 32'h00000280);

        // Read at 0x20
        base = strobes;
        cs_low();
        xfer(64'h20, 8, rx);
        check("rd_miso_cmd", rx[31:0], 32'h0);
        xfer(64'h0, 32, rx);
        check("rd_data_20", rx[31:0], 32'h0000000A);
        #(HALF);
        spi_cs_n = 1'b1;
        repeat (4) @(negedge clk);
        check("rd_miso_idle", {31'h0, spi_miso}, 32'h0);
        #(3 * HALF);
        check("rd_no_strobe", strobes - base, 0);

        // Read with address low bits forced to zero: 0x3F -> 0x3C
        cs_low();
        xfer(64'h3F, 8, rx);
`ifdef REG_SPI_AUTOINC_EN
        xfer(64'h0, 64, rx);
        check("rd_burst_w0", rx[63:32], 32'h80000001);
        check("rd_burst_w1", rx[31:0], 32'hCAFEF00D);
`else
        xfer(64'h0, 32, rx);
        check("rd_data_3c", rx[31:0], 32'h80000001);
`endif
        cs_high();
        check("rd3c_no_strobe", strobes - base, 0);

        // Abort after two data bytes, then a clean write
        base = strobes;
        cs_low();
        xfer(64'h88, 8, rx);
        xfer(64'hABCD, 16, rx);
        cs_high();
        check("abort_count", strobes - base, 0);
        write_word(8'h8C, 32'hDEADBEEF);
        check("post_abort_cnt", strobes - base, 1);
        check("post_abort_addr", {26'h0, s_addr[base]}, 32'h0C);
        check("post_abort_data", s_data[base], 32'hDEADBEEF);

        // cs_n rise together with the 32nd sck rise: bit is dropped
        base = strobes;
        cs_low();
        xfer(64'h90, 8, rx);
        xfer(64'h7FFFFFFF, 31, rx);
        spi_mosi = 1'b1;
        #(HALF);
        spi_sck = 1'b1;
        spi_cs_n = 1'b1;
        #(HALF);
        spi_sck = 1'b0;
        #(4 * HALF);
        check("cs_wins_count", strobes - base, 0);

        // Burst from 0x3C
        base = strobes;
        cs_low();
        xfer(64'hBC, 8, rx);
        xfer(64'h11111111_22222222, 64, rx);
        cs_high();
`ifdef REG_SPI_AUTOINC_EN
        check("burst_count", strobes - base, 2);
        check("burst_addr0", {26'h0, s_addr[base]}, 32'h3C);
        check("burst_data0", s_data[base], 32'h11111111);
        check("burst_addr1", {26'h0, s_addr[base+1]}, 32'h00);
        check("burst_data1", s_data[base+1], 32'h22222222);
`else
        check("burst_count", strobes - base, 1);
        check("burst_addr0", {26'h0, s_addr[base]}, 32'h3C);
        check("burst_data0", s_data[base], 32'h11111111);
`endif

        // Reset after 20 data bits of a write
        base = strobes;
        cs_low();
        xfer(64'h80, 8, rx);
        xfer(64'hFFFFF, 20, rx);
        reset_n = 1'b0;
        #1;
        check("midrst_addr", {26'h0, reg_addr}, 32'h0);
        check("midrst_wdata", reg_wdata, 32'h0);
        check("midrst_wstrobe", {31'h0, reg_wstrobe}, 32'h0);
        check("midrst_miso", {31'h0, spi_miso}, 32'h0);
        #29;
        reset_n = 1'b1;
        xfer(64'hFFF, 12, rx);
        cs_high();
        check("midrst_count", strobes - base, 0);
        write_word(8'h80, 32'h12345678);
        check("postrst_count", strobes - base, 1);
        check("postrst_addr", {26'h0, s_addr[base]}, 32'h00);
        check("postrst_data", s_data[base], 32'h12345678);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_spi_bridge.md
REG_SPI_BRIDGE -- requirements
Module: reg_spi_bridge

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all logic is in this domain.
REQ-002 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have port spi_sck, input, 1 bit: SPI clock from the MCU, mode 0, asynchronous to clk.
REQ-004 SHALL have port spi_cs_n, input, 1 bit: active-low chip select from the MCU, asynchronous.
REQ-005 SHALL have port spi_mosi, input, 1 bit: MCU-to-FPGA data, MSB first.
REQ-006 SHALL have port spi_miso, output, 1 bit: FPGA-to-MCU data, MSB first.
REQ-007 SHALL have port reg_addr, output, 6 bits: register byte address, with bits 1:0 always 0.
REQ-008 SHALL have port reg_wdata, output, 32 bits: register write data.
REQ-009 SHALL have port reg_wstrobe, output, 1 bit: one-clk write pulse.
REQ-010 SHALL have port reg_rdata, input, 32 bits: combinational read data from the responder for the current reg_addr.

Function
REQ-011 SHALL pass spi_sck, spi_cs_n and spi_mosi each through a 2-flop synchroniser and detect sck edges on the synchronised signals; clk SHALL be at least 6x the spi_sck frequency.
REQ-012 SHALL implement states IDLE, CMD, RD_LATCH, DATA and DONE.
REQ-013 IDLE -> CMD on synchronised cs_n falling, clearing the bit counter.
REQ-014 In CMD, SHALL shift in mosi on each sck rise; after 8 bits, cmd[7]=1 means write and 0 means read; cmd[5:0] with bits 1:0 forced to 0 loads reg_addr.
REQ-015 Write path: CMD -> DATA; DATA shifts 32 bits into reg_wdata.
REQ-016 On the 32nd bit of a write word, reg_wstrobe SHALL pulse high for exactly one clk on the following cycle, with reg_addr and reg_wdata stable during that cycle.
REQ-017 Read path: CMD -> RD_LATCH, which lasts 1 clk and captures reg_rdata into a 32-bit shift register; then -> DATA.
REQ-018 On read, spi_miso SHALL present the shift register MSB and SHALL advance on each sck fall.
REQ-019 The first read data bit SHALL be valid before the first data-phase sck rise.
REQ-020 spi_miso SHALL be 0 whenever synchronised cs_n is high or the state is not DATA on a read.
REQ-021 After the 32nd data bit, the block SHALL go to DONE, or continue a burst per REQ-029.
REQ-022 DONE SHALL ignore sck until cs_n rises.
REQ-023 cs_n rising in any state SHALL return to IDLE in the next clk with no reg_wstrobe; a partially shifted write word SHALL be discarded.
REQ-024 Simultaneous sck rise and cs_n rise: the cs_n rise SHALL win and the bit SHALL NOT be counted.
REQ-025 reg_wstrobe SHALL never assert in read transactions, RD_LATCH or IDLE.

Reset
REQ-026 reset_n low SHALL asynchronously force state IDLE and clear the bit counter and synchronisers (cs_n synchroniser to 1).
REQ-027 Reset values SHALL be reg_addr=0, reg_wdata=0, reg_wstrobe=0 and spi_miso=0.
REQ-028 A reset asserted mid-transaction SHALL abort it with no strobe; after release the block SHALL wait for a fresh cs_n falling edge.

Configuration
REQ-029 With macro REG_SPI_AUTOINC_EN defined: after each 32-bit word, reg_addr SHALL increment by 4, wrapping modulo 64 (0x3C -> 0x00), and the block SHALL stay in DATA; reads SHALL re-enter RD_LATCH to capture the next word.
REQ-030 Without REG_SPI_AUTOINC_EN: exactly one word per chip-select, then DONE.

Structure
REQ-031 A shared package SHALL hold the state encoding, the command bit positions (CMD_WRITE_BIT=7, address field 5:0), the word length 32 and the synchroniser depth 2.
REQ-032 One sub-module, spi_sync_edge, SHALL provide the 2-flop synchroniser with rise/fall pulse outputs, instantiated per SPI input; all other logic SHALL be flat in reg_spi_bridge.

Verification
REQ-033 Write: cmd 0x84 then bytes 00 00 02 80 -> one reg_wstrobe with reg_addr=0x04 and reg_wdata=0x00000280.
REQ-034 Read: cmd 0x20 with reg_rdata=0x0000000A -> 32 miso bits 0x0000000A MSB first, with no reg_wstrobe.
REQ-035 Abort: cmd 0x88 and 2 data bytes, then cs_n high -> no reg_wstrobe, state IDLE, next transaction correct.
REQ-036 Burst (macro on): cmd 0xBC and 8 data bytes 11111111 22222222 -> strobes at 0x3C (0x11111111) then 0x00 (0x22222222); macro off -> a single strobe at 0x3C only.
REQ-037 Reset: reset_n pulsed low after 20 data bits of a write -> no strobe, all outputs 0, and a following cmd 0x80 write works.
